// File: rtl/rv_pkg.sv
// Shared fetch-stage constants, FSM state encoding and the buffered fetch entry layout.
package rv_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } if_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_ent_t;

endpackage

// File: rtl/stage_if_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface stage_if_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata
   );

endinterface

// File: rtl/if_fifo.sv
// Two-entry FIFO holding fetched {pc,inst} pairs ahead of the decode register.
module if_fifo #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] mem_q [2];
   logic         wr_q, rd_q;
   logic [1:0]   cnt_q;
   logic         do_pop;

   assign empty  = (cnt_q == 2'd0);
   assign full   = (cnt_q == 2'd2);
   assign count  = cnt_q;
   assign rdata  = mem_q[rd_q];
   assign do_pop = pop && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= '0;
      end else if (clear) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (push)   wr_q <= ~wr_q;
         if (do_pop) rd_q <= ~rd_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wr_q] <= wdata;
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst) !(push && full && !clear));

endmodule

// File: rtl/stage_if.sv
// Fetch stage: keeps at most two fetches in flight or buffered, drops stale responses
// after a redirect and presents one instruction per cycle to decode.
module stage_if #(
   parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC,
   parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrl_stall,
   input  logic        ex_br_taken,
   input  logic [31:0] ex_br_addr,
   stage_if_if.master  imem,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        if_valid
);

   rv_pkg::if_state_e  state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [1:0]         outst_q, outst_d;
   logic [1:0]         drop_q, drop_d;
   logic [31:0]        inst_q, inst_d;
   logic [31:0]        opc_q, opc_d;
   logic               vld_q, vld_d;

   logic               run, req, grant, rv, keep, push, pop, clear;
   logic               fifo_full, fifo_empty;
   logic [1:0]         fifo_cnt;
   rv_pkg::fetch_ent_t resp, head;

   assign run   = (state_q == rv_pkg::RUN);
   assign rv    = run && imem.imem_rvalid;
   assign req   = run && !ex_br_taken && (({1'b0, outst_q} + {1'b0, fifo_cnt}) < 3'd2);
   assign grant = req && imem.imem_gnt;
   assign keep  = rv && !ex_br_taken && (drop_q == 2'd0);
   // Responses are in order, so with nothing left to drop the oldest live request is outst_q words behind pc.
   assign resp.pc   = pc_q - {28'd0, outst_q, 2'b00};
   assign resp.inst = imem.imem_rdata;
   assign pop   = run && !ex_br_taken && !ctrl_stall && !fifo_empty;
   assign push  = keep && (ctrl_stall || !fifo_empty);
   assign clear = run && ex_br_taken;

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_q;
   assign if_inst  = inst_q;
   assign if_pc    = opc_q;
   assign if_valid = vld_q;

   if_fifo #(.W($bits(rv_pkg::fetch_ent_t))) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (clear),
      .wdata (resp),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      outst_d = outst_q;
      drop_d  = drop_q;
      inst_d  = inst_q;
      opc_d   = opc_q;
      vld_d   = vld_q;
      case (state_q)
         rv_pkg::BOOT: state_d = rv_pkg::RUN;
         rv_pkg::RUN: begin
            if (ex_br_taken) begin
               pc_d    = ex_br_addr;
               outst_d = outst_q - {1'b0, rv};
               drop_d  = outst_q - {1'b0, rv};
               inst_d  = NOP_INST;
               opc_d   = '0;
               vld_d   = 1'b0;
            end else begin
               if (grant) pc_d = pc_q + 32'd4;
               outst_d = outst_q + {1'b0, grant} - {1'b0, rv};
               if (rv && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
               if (!ctrl_stall) begin
                  if (!fifo_empty) begin
                     inst_d = head.inst;
                     opc_d  = head.pc;
                     vld_d  = 1'b1;
                  end else if (keep) begin
                     inst_d = resp.inst;
                     opc_d  = resp.pc;
                     vld_d  = 1'b1;
                  end else begin
                     inst_d = NOP_INST;
                     opc_d  = '0;
                     vld_d  = 1'b0;
                  end
               end
            end
         end
         default: state_d = rv_pkg::BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= rv_pkg::BOOT;
         pc_q    <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
         inst_q  <= NOP_INST;
         opc_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
         inst_q  <= inst_d;
         opc_q   <= opc_d;
         vld_q   <= vld_d;
      end
   end

   a_full_idle : assert property (@(posedge clk) disable iff (!rst) fifo_full |-> (outst_q == 2'd0));

endmodule

// File: tb/tb_stage_if.sv
// Randomized fetch-stage bench with a queue-based reference model and directed scenarios.
module tb_stage_if;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ctrl_stall = 1'b0;
   logic        ex_br_taken = 1'b0;
   logic [31:0] ex_br_addr = '0;
   logic [31:0] if_inst, if_pc;
   logic        if_valid;

   stage_if_if imem();

   stage_if #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
      .clk         (clk),
      .rst         (rst),
      .ctrl_stall  (ctrl_stall),
      .ex_br_taken (ex_br_taken),
      .ex_br_addr  (ex_br_addr),
      .imem        (imem),
      .if_inst     (if_inst),
      .if_pc       (if_pc),
      .if_valid    (if_valid)
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // reference model: requested addresses awaiting response, buffered fetches, expected outputs
   logic [31:0] m_pc;
   bit          m_boot;
   logic [31:0] pend[$];
   bit          stale[$];
   logic [63:0] bufq[$];
   logic [31:0] e_inst, e_pc;
   logic        e_valid;

   int unsigned p_gnt, p_rv, p_stall, p_br;
   bit          rnd_tgt;
   logic [31:0] a_inst, a_pc, a_addr;
   logic        a_valid, a_req;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hA5A5_0003;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_boot  = 1'b1;
      m_pc    = 32'h0000_0000;
      pend.delete();
      stale.delete();
      bufq.delete();
      e_inst  = 32'h0000_0013;
      e_pc    = '0;
      e_valid = 1'b0;
   endtask

   task automatic cycle();
      bit          exp_req, grant, has, s;
      logic [31:0] a;
      logic [63:0] ent;
      @(negedge clk);
      a_inst = if_inst; a_pc = if_pc; a_valid = if_valid;
      chk("valid", a_valid, e_valid);
      chk("inst", a_inst, e_inst);
      if (e_valid) chk("pc", a_pc, e_pc);
      ctrl_stall  = ($urandom_range(0, 99) < p_stall);
      ex_br_taken = ($urandom_range(0, 99) < p_br);
      if (ex_br_taken && rnd_tgt)
         ex_br_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      imem.imem_gnt    = ($urandom_range(0, 99) < p_gnt);
      imem.imem_rvalid = (pend.size() > 0) && ($urandom_range(0, 99) < p_rv);
      imem.imem_rdata  = imem.imem_rvalid ? inst_of(pend[0]) : $urandom();
      #1;
      exp_req = !m_boot && (pend.size() + bufq.size() < 2) && !ex_br_taken;
      a_req = imem.imem_req; a_addr = imem.imem_addr;
      chk("req", a_req, exp_req);
      if (exp_req) chk("addr", a_addr, m_pc);
      @(posedge clk);
      if (m_boot) begin
         m_boot = 1'b0;
      end else begin
         has = 1'b0;
         if (imem.imem_rvalid) begin
            a = pend.pop_front();
            s = stale.pop_front();
            if (!s && !ex_br_taken) begin
               ent = {a, inst_of(a)};
               has = 1'b1;
            end
         end
         if (ex_br_taken) begin
            foreach (stale[i]) stale[i] = 1'b1;
            bufq.delete();
            e_valid = 1'b0;
            e_inst  = 32'h0000_0013;
            m_pc    = ex_br_addr;
         end else begin
            grant = exp_req && imem.imem_gnt;
            if (!ctrl_stall) begin
               if (bufq.size() > 0) begin
                  {e_pc, e_inst} = bufq.pop_front();
                  e_valid = 1'b1;
                  if (has) bufq.push_back(ent);
               end else if (has) begin
                  {e_pc, e_inst} = ent;
                  e_valid = 1'b1;
               end else begin
                  e_valid = 1'b0;
                  e_inst  = 32'h0000_0013;
               end
            end else if (has) begin
               bufq.push_back(ent);
            end
            if (grant) begin
               pend.push_back(m_pc);
               stale.push_back(1'b0);
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ctrl_stall = 1'b0; ex_br_taken = 1'b0;
      imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
      #1;
      chk("rst_inst", if_inst, 32'h0000_0013);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_valid", if_valid, 1'b0);
      chk("rst_req", imem.imem_req, 1'b0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   initial begin
      bit found, seen_req;
      imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
      p_gnt = 100; p_rv = 100; p_stall = 0; p_br = 0; rnd_tgt = 1'b0;
      #3 do_reset();

      // start-up: boot cycle quiet, then back-to-back fetch from 0
      cycle(); chk("boot_noreq", a_req, 1'b0);
      cycle(); chk("first_req", a_req, 1'b1); chk("first_addr", a_addr, 32'h0);
      cycle(); chk("second_addr", a_addr, 32'h4);
      cycle(); chk("first_inst", a_inst, 32'hA5A5_0003); chk("first_pc", a_pc, 32'h0);
      chk("first_valid", a_valid, 1'b1);
      cycle(); chk("pc_4", a_pc, 32'h4);
      cycle(); chk("pc_8", a_pc, 32'h8);

      // grant withheld: request held with a stable address
      p_gnt = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(); chk("nognt_req", a_req, 1'b1); chk("nognt_addr", a_addr, 32'h14);
      end
      p_gnt = 100;
      for (int i = 0; i < 3; i++) cycle();

      // stall with the pipe filling up
      p_stall = 100;
      cycle(); chk("stall_pc0", a_pc, 32'h18); chk("stall_valid", a_valid, 1'b1);
      cycle(); chk("stall_pc1", a_pc, 32'h18);
      cycle(); chk("stall_pc2", a_pc, 32'h18); chk("stall_full_noreq", a_req, 1'b0);
      p_stall = 0;
      cycle(); chk("stall_pc3", a_pc, 32'h18); chk("stall_inst", a_inst, 32'hA5A5_001B);
      cycle(); chk("release_pc1", a_pc, 32'h1C);
      cycle(); chk("release_pc2", a_pc, 32'h20);

      // redirect with two requests in flight
      p_rv = 0;
      for (int i = 0; i < 8 && pend.size() < 2; i++) cycle();
      chk("two_outstanding", pend.size(), 32'd2);
      p_br = 100; ex_br_addr = 32'h100;
      cycle(); chk("br_noreq", a_req, 1'b0);
      p_br = 0; p_rv = 100;
      cycle(); chk("br_bubble", a_valid, 1'b0);
      found = 1'b0; seen_req = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         cycle();
         if (a_req && !seen_req) begin
            seen_req = 1'b1;
            chk("redir_addr", a_addr, 32'h100);
         end
         if (a_valid) begin
            found = 1'b1;
            chk("redir_pc", a_pc, 32'h100);
            chk("redir_inst", a_inst, 32'hA5A5_0103);
         end
      end
      chk("redir_arrived", found, 1'b1);

      // flush and stall together: flush wins
      cycle(); cycle();
      p_stall = 100; p_br = 100; ex_br_addr = 32'h200;
      cycle();
      p_stall = 0; p_br = 0;
      cycle(); chk("flush_wins_valid", a_valid, 1'b0); chk("flush_wins_inst", a_inst, 32'h13);

      // random traffic
      p_gnt = 70; p_rv = 60; p_stall = 25; p_br = 4; rnd_tgt = 1'b1;
      for (int i = 0; i < 3000; i++) cycle();

      // asynchronous reset mid-stream, then restart from RESET_PC
      #3 do_reset();
      p_gnt = 100; p_rv = 100; p_stall = 0; p_br = 0;
      cycle(); chk("rst2_boot_noreq", a_req, 1'b0);
      cycle(); chk("rst2_req", a_req, 1'b1); chk("rst2_addr", a_addr, 32'h0);
      p_gnt = 70; p_rv = 60; p_stall = 25; p_br = 4;
      for (int i = 0; i < 1000; i++) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
